// File: rtl/counter_ctrl_if.sv
// Control and status bundle for counter_ctrl: configuration, run-control pulses and counter status.
interface counter_ctrl_if #(
    parameter int WIDTH = 32
) ();
    logic             cfg_load;
    logic [WIDTH-1:0] cfg_period;
    logic             cfg_periodic;
    logic             start;
    logic             pause;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic [1:0]       state;
    logic             busy;
    logic             expire;
    logic [15:0]      wraps;

    modport master (
        output cfg_load, cfg_period, cfg_periodic, start, pause, stop,
        input  count, state, busy, expire, wraps
    );

    modport slave (
        input  cfg_load, cfg_period, cfg_periodic, start, pause, stop,
        output count, state, busy, expire, wraps
    );
endinterface

// File: rtl/counter_ctrl.sv
// Prescaled period counter with one-shot/auto-reload modes, pause/resume and a saturating
// completed-period counter.
module counter_ctrl #(
    parameter int WIDTH = 32,
    parameter int DIV   = 1
) (
    input  logic          clk,
    input  logic          rst,
    counter_ctrl_if.slave bus
);
    // state  | meaning
    // IDLE   | cleared, waiting for start
    // RUN    | prescaler and count advancing
    // PAUSED | count and prescaler frozen
    // DONE   | one-shot complete, count held at period
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        DONE   = 2'b11
    } state_e;

    localparam logic [15:0] PRESC_LAST = 16'(DIV - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             periodic_q, periodic_d;
    logic [15:0]      presc_q, presc_d;
    logic [15:0]      wraps_q, wraps_d;
    logic             expire_q, expire_d;
    logic             advance;
    logic             settled;
    logic             tick;
    logic             terminal;

    assign settled  = (state_q == IDLE) || (state_q == DONE);
    assign tick     = (presc_q == PRESC_LAST);
    assign terminal = (count_q == period_q - WIDTH'(1));

    // Only the highest-priority pulse is considered; an accepted stop or pause
    // suppresses this edge's counting, including a terminal tick.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        presc_d    = presc_q;
        wraps_d    = wraps_q;
        expire_d   = 1'b0;
        advance    = (state_q == RUN);

        if (bus.stop) begin
            state_d = IDLE;
            count_d = '0;
            presc_d = '0;
            wraps_d = '0;
            advance = 1'b0;
        end else if (bus.cfg_load) begin
            if (settled) begin
                period_d   = bus.cfg_period;
                periodic_d = bus.cfg_periodic;
                count_d    = '0;
                presc_d    = '0;
                wraps_d    = '0;
                state_d    = IDLE;
            end
        end else if (bus.start) begin
            if (settled && (period_q != '0)) begin
                state_d = RUN;
                count_d = '0;
                presc_d = '0;
                wraps_d = '0;
            end else if (state_q == PAUSED) begin
                state_d = RUN;
            end
        end else if (bus.pause) begin
            if (state_q == RUN) begin
                state_d = PAUSED;
                advance = 1'b0;
            end
        end

        if (advance) begin
            if (tick) begin
                presc_d = '0;
                if (terminal) begin
                    expire_d = 1'b1;
                    if (wraps_q != 16'hFFFF) begin
                        wraps_d = wraps_q + 16'd1;
                    end
                    if (periodic_q) begin
                        count_d = '0;
                    end else begin
                        count_d = period_q;
                        state_d = DONE;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            presc_q    <= '0;
            wraps_q    <= '0;
            expire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            presc_q    <= presc_d;
            wraps_q    <= wraps_d;
            expire_q   <= expire_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.state  = state_q;
    assign bus.busy   = (state_q == RUN) || (state_q == PAUSED);
    assign bus.expire = expire_q;
    assign bus.wraps  = wraps_q;
endmodule
